// File: rtl/dmem_wait_responder.sv
// Multi-cycle data memory for the MEM stage: stalls the pipeline for WAIT_CYCLES
// wait states per aligned access and flags misaligned requests for one cycle.
module dmem_wait_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 memRead,
    input  logic                 memWrite,
    input  logic [31:0]          address,
    input  logic [31:0]          writeData,
    output logic [31:0]          readData,
    output logic                 memStall,
    output logic                 misaligned,
    output logic [CNT_WIDTH-1:0] accessCount
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   is_wr_q, is_wr_d;
    logic                   err_q, err_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [CNT_WIDTH-1:0]   acc_q, acc_d;
    logic                   stall;
    logic                   mem_we;
    logic                   req;
    logic                   unused_addr_bits;

    logic [31:0] mem_q [DEPTH_WORDS];

    assign req = memRead | memWrite;
    // Addresses wrap modulo the array size; the upper bits are deliberately dropped.
    assign unused_addr_bits = ^address[31:AW+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        acc_d   = acc_q;
        stall   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                stall = req;
                if (req) begin
                    if (address[1:0] == 2'b00) begin
                        idx_d   = address[AW+1:2];
                        wdata_d = writeData;
                        is_wr_d = memWrite;
                        cnt_d   = WAIT_INIT;
                        state_d = BUSY;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // A simultaneous read+write request was captured as a write.
                    if (is_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem_q[idx_q];
                    end
                    acc_d   = acc_q + CNT_WIDTH'(1);
                    state_d = DONE;
                end
            end
            DONE: begin
                // Leaving unconditionally lets the pipeline advance past the held request.
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            is_wr_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            acc_q   <= acc_d;
        end
    end

    // Array has no reset; a write in flight is dropped because reset forces IDLE.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign readData    = rdata_q;
    assign memStall    = stall & rst_n;
    assign misaligned  = (state_q == DONE) & err_q;
    assign accessCount = acc_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Bench for dmem_wait_responder: two instances (WAIT_CYCLES=2 and 0) checked against
// a word-array reference model with directed and randomized accesses.
module tb_dmem_wait_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mr [2];
    logic        mw [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [31:0] rd [2];
    logic        st [2];
    logic        mis [2];
    logic [15:0] cnt [2];

    always #5 clk = ~clk;

    dmem_wait_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .CNT_WIDTH(16)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .memRead(mr[0]), .memWrite(mw[0]),
        .address(ad[0]), .writeData(wd[0]), .readData(rd[0]),
        .memStall(st[0]), .misaligned(mis[0]), .accessCount(cnt[0])
    );

    dmem_wait_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .CNT_WIDTH(16)) dut_w0 (
        .clk(clk), .rst_n(rst_n), .memRead(mr[1]), .memWrite(mw[1]),
        .address(ad[1]), .writeData(wd[1]), .readData(rd[1]),
        .memStall(st[1]), .misaligned(mis[1]), .accessCount(cnt[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain word arrays per instance.
    logic [31:0] mm [2][256];
    bit          vld [2][256];
    logic [31:0] exp_rd [2];
    bit          rd_known [2];
    int          exp_cnt [2];

    function automatic int waits(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            exp_rd[i]   = 32'd0;
            rd_known[i] = 1'b1;
            exp_cnt[i]  = 0;
        end
    endtask

    task automatic do_access(input int i, input logic r, input logic w,
                             input logic [31:0] a, input logic [31:0] d, input string nm);
        int cyc;
        int exp_st;
        bit mis_exp;
        int idx;
        @(negedge clk);
        mr[i] = r; mw[i] = w; ad[i] = a; wd[i] = d;
        #1;
        mis_exp = (a[1:0] != 2'b00);
        exp_st  = mis_exp ? 1 : waits(i) + 2;
        idx     = int'(a[9:2]);
        cyc     = 0;
        while (st[i] === 1'b1 && cyc < 64) begin
            @(negedge clk);
            #1;
            cyc++;
            wd[i] = $urandom();
        end
        if (!mis_exp) begin
            if (w) begin
                mm[i][idx]  = d;
                vld[i][idx] = 1'b1;
            end else begin
                exp_rd[i]   = mm[i][idx];
                rd_known[i] = vld[i][idx];
            end
            exp_cnt[i] = (exp_cnt[i] + 1) & 16'hFFFF;
        end
        checks++;
        if (cyc != exp_st) begin
            errors++;
            $display("FAIL %s stall_len inst%0d: got %0d cycles, expected %0d", nm, i, cyc, exp_st);
        end
        checks++;
        if (mis[i] !== mis_exp) begin
            errors++;
            $display("FAIL %s misaligned inst%0d: got %b, expected %b", nm, i, mis[i], mis_exp);
        end
        if (rd_known[i]) begin
            checks++;
            if (rd[i] !== exp_rd[i]) begin
                errors++;
                $display("FAIL %s readData inst%0d: got %h, expected %h", nm, i, rd[i], exp_rd[i]);
            end
        end
        checks++;
        if (cnt[i] !== 16'(exp_cnt[i])) begin
            errors++;
            $display("FAIL %s accessCount inst%0d: got %0d, expected %0d", nm, i, cnt[i], exp_cnt[i]);
        end
        $display("txn %s inst%0d rd=%b wr=%b addr=%h wdata=%h stall=%0d readData=%h count=%0d",
                 nm, i, r, w, a, d, cyc, rd[i], cnt[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                mr[i] = 1'b0; mw[i] = 1'b0;
            end
            #1;
            checks++;
            if ({st[0], st[1], mis[0], mis[1]} !== 4'b0000) begin
                errors++;
                $display("FAIL idle_quiet: stall=%b%b misaligned=%b%b, expected all 0",
                         st[0], st[1], mis[0], mis[1]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mr[i] = 1'b0; mw[i] = 1'b0; ad[i] = 32'd0; wd[i] = 32'd0;
        end
        repeat (2) @(negedge clk);
        mr[0] = 1'b1;
        mw[1] = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rd[i] !== 32'd0 || cnt[i] !== 16'd0 || st[i] !== 1'b0 || mis[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state inst%0d: readData=%h count=%0d stall=%b mis=%b, expected 0/0/0/0",
                         i, rd[i], cnt[i], st[i], mis[i]);
            end
        end
        mr[0] = 1'b0;
        mw[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        $display("txn reset done");
    endtask

    task automatic test_store_load();
        do_access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "store_0x10");
        idle(1);
        do_access(0, 1'b1, 1'b0, 32'h10, 32'h0, "load_0x10");
        idle(1);
    endtask

    task automatic test_wait0();
        do_access(1, 1'b0, 1'b1, 32'h4, 32'h5, "w0_store_0x4");
        idle(1);
        do_access(1, 1'b1, 1'b0, 32'h4, 32'h0, "w0_load_0x4");
        idle(1);
    endtask

    task automatic test_misaligned();
        do_access(0, 1'b1, 1'b0, 32'h13, 32'h0, "misaligned_0x13");
        idle(1);
        do_access(1, 1'b0, 1'b1, 32'h6, 32'h77, "w0_misaligned_0x6");
        idle(1);
    endtask

    task automatic test_wrap_priority();
        do_access(0, 1'b0, 1'b1, 32'h400, 32'h11111111, "store_0x400");
        idle(1);
        do_access(0, 1'b1, 1'b0, 32'h0, 32'h0, "wrap_load_0x0");
        idle(1);
        do_access(0, 1'b1, 1'b1, 32'h8, 32'h22, "both_0x8");
        idle(1);
        do_access(0, 1'b1, 1'b0, 32'h8, 32'h0, "load_0x8");
        idle(1);
    endtask

    task automatic test_reset_mid_access();
        do_access(0, 1'b0, 1'b1, 32'h40, 32'hCAFE0001, "pre_store_0x40");
        idle(1);
        @(negedge clk);
        mw[0] = 1'b1; ad[0] = 32'h40; wd[0] = 32'h0BADBAD0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd[0] !== 32'd0 || st[0] !== 1'b0 || cnt[0] !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_access: readData=%h stall=%b count=%0d, expected 0/0/0",
                     rd[0], st[0], cnt[0]);
        end
        mw[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        $display("txn reset mid-access");
        idle(1);
        do_access(0, 1'b1, 1'b0, 32'h40, 32'h0, "load_after_reset_0x40");
        idle(1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            int c0;
            c0 = exp_cnt[i];
            do_access(i, 1'b1, 1'b0, 32'h40, 32'h0, "b2b_load");
            do_access(i, 1'b0, 1'b1, 32'h44, 32'h55, "b2b_store");
            idle(3);
            checks++;
            if (cnt[i] !== 16'((c0 + 2) & 16'hFFFF)) begin
                errors++;
                $display("FAIL b2b_count inst%0d: got %0d, expected %0d", i, cnt[i], c0 + 2);
            end
            do_access(i, 1'b1, 1'b0, 32'h44, 32'h0, "b2b_check_load");
            idle(1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 40; n++) begin
                logic        r;
                logic        w;
                logic [31:0] a;
                int          op;
                op = $urandom_range(0, 7);
                r  = (op < 4) || (op == 7);
                w  = (op >= 4);
                a  = {$urandom_range(0, 1023), 22'(0)} | (32'($urandom_range(0, 15)) << 2);
                if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
                do_access(i, r, w, a, $urandom(), "random");
                if ($urandom_range(0, 1) == 1) idle(1);
            end
            idle(1);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_wait0();
        test_misaligned();
        test_wrap_priority();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
